dcache_axi_master: RTL and testbench

- Downstream of the L1 data cache. Converts the cache's memory-side request/wait handshake (D_req/D_addr/D_write/D_in/D_type in, D_out/D_wait out) into AXI4 master transactions on the data port of the CPU wrapper.
- Cacheable reads are one 4-beat INCR burst (line fill). Uncacheable reads and all writes are single-beat.
- Delivers each returned word to the cache as a one-cycle D_wait=0 pulse.

---
 rtl/dcache_axi_master_if.sv | 49 ++++
 rtl/dcache_axi_master.sv | 160 ++++++++++++++++
 tb/tb_dcache_axi_master.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dcache_axi_master_if.sv
// AXI4 bus bundle for the data-cache memory port.
// The master modport faces the cache side. The slave modport faces the interconnect or memory model.
interface dcache_axi_master_if;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID, BREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/dcache_axi_master.sv
// Bridges the L1 data cache request/wait handshake onto an AXI4 master port.
// Cacheable reads become 4-beat line fills. Uncached reads and all writes are single-beat.
module dcache_axi_master #(
  parameter logic [3:0]  ID           = 4'd1,
  parameter logic [15:0] UNCACHE_BASE = 16'h1000,
  parameter int          LINE_BEATS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        D_req,
  input  logic [31:0] D_addr,
  input  logic        D_write,
  input  logic [31:0] D_in,
  input  logic [2:0]  D_type,
  output logic [31:0] D_out,
  output logic        D_wait,
  output logic        bus_err,
  dcache_axi_master_if.master axi
);
  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

  localparam logic [3:0] BURST_LEN = 4'(LINE_BEATS - 1);

  state_t      state;
  logic        pulse;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        aw_done, w_done;
  logic [3:0]  beat;
  logic [3:0]  arlen_q;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        aw_hs, w_hs, is_burst;
  logic        unused_ok;

  function automatic logic [3:0] wstrb_for(input logic [2:0] typ, input logic [1:0] lo);
    case (typ)
      3'b000:  return 4'b0001 << lo;
      3'b001:  return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  assign is_burst = (D_addr[31:16] != UNCACHE_BASE);
  assign aw_hs    = awvalid & axi.AWREADY;
  assign w_hs     = wvalid & axi.WREADY;

  assign D_wait       = ~pulse;
  assign axi.ARID     = ID;
  assign axi.ARADDR   = araddr;
  assign axi.ARLEN    = arlen_q;
  assign axi.ARSIZE   = 3'b010;
  assign axi.ARBURST  = 2'b01;
  assign axi.ARVALID  = arvalid;
  assign axi.RREADY   = rready;
  assign axi.AWID     = ID;
  assign axi.AWADDR   = awaddr;
  assign axi.AWLEN    = 4'd0;
  assign axi.AWSIZE   = 3'b010;
  assign axi.AWBURST  = 2'b01;
  assign axi.AWVALID  = awvalid;
  assign axi.WDATA    = wdata;
  assign axi.WSTRB    = wstrb;
  assign axi.WLAST    = 1'b1;
  assign axi.WVALID   = wvalid;
  assign axi.BREADY   = bready;

  // Only one transaction is ever outstanding, so response IDs carry no information.
  assign unused_ok = ^{axi.RID, axi.BID};

  // Request capture: address, data and strobes are frozen on the IDLE cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && D_req) begin
      araddr  <= is_burst ? {D_addr[31:4], 4'h0} : D_addr;
      arlen_q <= is_burst ? BURST_LEN : 4'd0;
      awaddr  <= D_addr;
      wdata   <= D_in;
      wstrb   <= wstrb_for(D_type, D_addr[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      beat    <= 4'd0;
      pulse   <= 1'b0;
      D_out   <= 32'd0;
      bus_err <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (D_req) begin
            if (D_write) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= AW_W;
            end else begin
              arvalid <= 1'b1;
              state   <= AR;
            end
          end
        end
        AR: begin
          if (axi.ARREADY) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            beat    <= 4'd0;
            state   <= R;
          end
        end
        R: begin
          if (axi.RVALID) begin
            D_out <= axi.RDATA;
            pulse <= 1'b1;
            beat  <= beat + 4'd1;
            if (axi.RRESP != 2'b00) bus_err <= 1'b1;
            if (axi.RLAST || beat == arlen_q) begin
              rready <= 1'b0;
              state  <= DONE;
            end
          end
        end
        AW_W: begin
          // The address and data channels retire independently. Either order, or both at once, is legal.
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= B;
          end
        end
        B: begin
          if (axi.BVALID) begin
            bready <= 1'b0;
            pulse  <= 1'b1;
            if (axi.BRESP != 2'b00) bus_err <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_axi_master.sv
// Scenario bench for dcache_axi_master: read bursts, uncached reads, write strobes, errors, reset abort.
// Read data is scoreboarded through a queue and checked against each D_wait pulse.
module tb_dcache_axi_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        D_req, D_write;
  logic [31:0] D_addr, D_in, D_out;
  logic [2:0]  D_type;
  logic        D_wait, bus_err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  dcache_axi_master_if ax();

  dcache_axi_master #(.ID(4'd1), .UNCACHE_BASE(16'h1000), .LINE_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in), .D_type(D_type),
    .D_out(D_out), .D_wait(D_wait), .bus_err(bus_err),
    .axi(ax)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if ({ax.ARVALID, ax.RREADY, ax.AWVALID, ax.WVALID, ax.BREADY} !== 5'b0) begin n_fail++; $display("FAIL reset_handshakes: got %b want 00000", {ax.ARVALID, ax.RREADY, ax.AWVALID, ax.WVALID, ax.BREADY}); end
    n_checks++; if (D_out !== 32'd0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", D_out); end
    n_checks++; if (D_wait !== 1'b1) begin n_fail++; $display("FAIL reset_dwait: got %b want 1", D_wait); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_buserr: got %b want 0", bus_err); end
    rst = 1'b0;
    tick();
    n_checks++; if (D_wait !== 1'b1) begin n_fail++; $display("FAIL idle_dwait: got %b want 1", D_wait); end
  endtask

  task automatic test_cached_read();
    logic [31:0] rd [4];
    logic [31:0] exp;
    rd = '{32'h11, 32'h22, 32'h33, 32'h44};
    D_req = 1'b1; D_write = 1'b0; D_addr = 32'h0001_0024; D_type = 3'b010;
    tick();
    D_req = 1'b0; D_addr = 32'h1000_0000;
    n_checks++; if (ax.ARVALID !== 1'b1) begin n_fail++; $display("FAIL cr_arvalid: got %b want 1", ax.ARVALID); end
    n_checks++; if (ax.ARADDR !== 32'h0001_0020) begin n_fail++; $display("FAIL cr_araddr: got %h want 00010020", ax.ARADDR); end
    n_checks++; if (ax.ARLEN !== 4'd3) begin n_fail++; $display("FAIL cr_arlen: got %0d want 3", ax.ARLEN); end
    n_checks++; if ({ax.ARID, ax.ARSIZE, ax.ARBURST} !== {4'd1, 3'b010, 2'b01}) begin n_fail++; $display("FAIL cr_arattr: got %h/%b/%b want 1/010/01", ax.ARID, ax.ARSIZE, ax.ARBURST); end
    ax.ARREADY = 1'b1;
    tick();
    ax.ARREADY = 1'b0;
    n_checks++; if ({ax.ARVALID, ax.RREADY} !== 2'b01) begin n_fail++; $display("FAIL cr_rphase: got arvalid/rready %b want 01", {ax.ARVALID, ax.RREADY}); end
    for (int i = 0; i < 4; i++) exp_q.push_back(rd[i]);
    for (int i = 0; i < 4; i++) begin
      ax.RVALID = 1'b1; ax.RDATA = rd[i]; ax.RLAST = (i == 3); ax.RRESP = 2'b00;
      tick();
      n_checks++; if (D_wait !== 1'b0) begin n_fail++; $display("FAIL cr_pulse%0d: got D_wait %b want 0", i, D_wait); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (D_out !== exp) begin n_fail++; $display("FAIL cr_data%0d: got %h want %h", i, D_out, exp); end
    end
    ax.RVALID = 1'b0; ax.RLAST = 1'b0;
    n_checks++; if (ax.RREADY !== 1'b0) begin n_fail++; $display("FAIL cr_rready_done: got %b want 0", ax.RREADY); end
    tick();
    n_checks++; if (D_wait !== 1'b1) begin n_fail++; $display("FAIL cr_after: got D_wait %b want 1", D_wait); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cr_queue: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_uncached_read();
    logic [31:0] exp;
    D_req = 1'b1; D_write = 1'b0; D_addr = 32'h1000_0008; D_type = 3'b010;
    ax.ARREADY = 1'b1;
    tick();
    D_req = 1'b0; D_addr = 32'h0000_0000;
    n_checks++; if (ax.ARLEN !== 4'd0) begin n_fail++; $display("FAIL ur_arlen: got %0d want 0", ax.ARLEN); end
    n_checks++; if (ax.ARADDR !== 32'h1000_0008) begin n_fail++; $display("FAIL ur_araddr: got %h want 10000008", ax.ARADDR); end
    tick();
    ax.ARREADY = 1'b0;
    n_checks++; if ({ax.RREADY, D_wait} !== 2'b11) begin n_fail++; $display("FAIL ur_rphase: got rready/dwait %b want 11", {ax.RREADY, D_wait}); end
    exp_q.push_back(32'hDEAD_BEEF);
    ax.RVALID = 1'b1; ax.RDATA = 32'hDEAD_BEEF; ax.RLAST = 1'b1; ax.RRESP = 2'b00;
    tick();
    ax.RVALID = 1'b0; ax.RLAST = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_checks++; if (D_wait !== 1'b0) begin n_fail++; $display("FAIL ur_pulse: got D_wait %b want 0 (3 cycles after req)", D_wait); end
    n_checks++; if (D_out !== exp) begin n_fail++; $display("FAIL ur_data: got %h want %h", D_out, exp); end
    tick();
    n_checks++; if (D_wait !== 1'b1) begin n_fail++; $display("FAIL ur_single: got D_wait %b want 1", D_wait); end
  endtask

  task automatic test_writes();
    logic [31:0] addr [4];
    logic [2:0]  typ  [4];
    logic [3:0]  strb [4];
    int          dly  [4];
    int          cyc, pulses;
    addr = '{32'h2000_0003, 32'h2000_0012, 32'h2000_0020, 32'h2000_0040};
    typ  = '{3'b000, 3'b001, 3'b010, 3'b010};
    strb = '{4'b1000, 4'b1100, 4'b1111, 4'b1111};
    dly  = '{0, 0, 0, 3};
    for (int r = 0; r < 4; r++) begin
      D_req = 1'b1; D_write = 1'b1; D_addr = addr[r]; D_in = 32'hA500_0000 + r; D_type = typ[r];
      tick();
      D_req = 1'b0; D_write = 1'b0; D_addr = ~addr[r]; D_in = 32'h0;
      n_checks++; if ({ax.AWVALID, ax.WVALID} !== 2'b11) begin n_fail++; $display("FAIL wr%0d_valids: got %b want 11", r, {ax.AWVALID, ax.WVALID}); end
      n_checks++; if (ax.WSTRB !== strb[r]) begin n_fail++; $display("FAIL wr%0d_wstrb: got %b want %b", r, ax.WSTRB, strb[r]); end
      n_checks++; if ({ax.AWADDR, ax.WDATA} !== {addr[r], 32'hA500_0000 + r}) begin n_fail++; $display("FAIL wr%0d_addr_data: got %h/%h want %h/%h", r, ax.AWADDR, ax.WDATA, addr[r], 32'hA500_0000 + r); end
      n_checks++; if ({ax.WLAST, ax.AWLEN, ax.AWID} !== {1'b1, 4'd0, 4'd1}) begin n_fail++; $display("FAIL wr%0d_attr: got wlast %b awlen %0d awid %0d want 1/0/1", r, ax.WLAST, ax.AWLEN, ax.AWID); end
      ax.WREADY = 1'b1; ax.AWREADY = (dly[r] == 0);
      cyc = 0; pulses = 0;
      while (ax.BREADY !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
        ax.WREADY = 1'b0;
        if (D_wait === 1'b0) pulses++;
        if (ax.BREADY !== 1'b1) begin
          n_checks++; if ({ax.AWVALID, ax.WVALID} !== 2'b10) begin n_fail++; $display("FAIL wr%0d_hold%0d: got aw/w %b want 10", r, cyc, {ax.AWVALID, ax.WVALID}); end
          ax.AWREADY = (cyc == dly[r]);
        end else begin
          ax.AWREADY = 1'b0;
        end
      end
      n_checks++; if (cyc != dly[r] + 1) begin n_fail++; $display("FAIL wr%0d_aw_cycles: got %0d want %0d", r, cyc, dly[r] + 1); end
      n_checks++; if ({ax.AWVALID, ax.WVALID} !== 2'b00) begin n_fail++; $display("FAIL wr%0d_bphase: got aw/w %b want 00", r, {ax.AWVALID, ax.WVALID}); end
      ax.BVALID = 1'b1; ax.BRESP = 2'b00;
      tick();
      ax.BVALID = 1'b0;
      n_checks++; if ({D_wait, ax.BREADY} !== 2'b00) begin n_fail++; $display("FAIL wr%0d_bdone: got dwait/bready %b want 00", r, {D_wait, ax.BREADY}); end
      tick();
      n_checks++; if (D_wait !== 1'b1) begin n_fail++; $display("FAIL wr%0d_single: got D_wait %b want 1", r, D_wait); end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL wr%0d_early_pulse: got %0d want 0", r, pulses); end
    end
  endtask

  task automatic test_rresp_err();
    logic [31:0] exp;
    int          pulses;
    D_req = 1'b1; D_write = 1'b0; D_addr = 32'h0002_0000;
    tick();
    D_req = 1'b0;
    ax.ARREADY = 1'b1;
    tick();
    ax.ARREADY = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0 + i);
    for (int i = 0; i < 4; i++) begin
      ax.RVALID = 1'b1; ax.RDATA = 32'hC0 + i; ax.RLAST = (i == 3); ax.RRESP = (i == 1) ? 2'b10 : 2'b00;
      tick();
      if (D_wait === 1'b0) pulses++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (D_out !== exp) begin n_fail++; $display("FAIL err_data%0d: got %h want %h", i, D_out, exp); end
      n_checks++; if (bus_err !== (i >= 1)) begin n_fail++; $display("FAIL err_flag%0d: got %b want %b", i, bus_err, (i >= 1)); end
    end
    ax.RVALID = 1'b0; ax.RLAST = 1'b0; ax.RRESP = 2'b00;
    n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL err_pulses: got %0d want 4", pulses); end
    tick();
    tick();
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", bus_err); end
  endtask

  task automatic test_reset_mid();
    D_req = 1'b1; D_write = 1'b0; D_addr = 32'h0003_0000;
    tick();
    D_req = 1'b0;
    ax.ARREADY = 1'b1;
    tick();
    ax.ARREADY = 1'b0;
    ax.RVALID = 1'b1; ax.RDATA = 32'hA1; ax.RLAST = 1'b0; ax.RRESP = 2'b00;
    tick();
    n_checks++; if ({D_wait, D_out} !== {1'b0, 32'hA1}) begin n_fail++; $display("FAIL rm_beat1: got dwait %b dout %h want 0/a1", D_wait, D_out); end
    rst = 1'b1; ax.RDATA = 32'hA2;
    tick();
    rst = 1'b0;
    n_checks++; if ({ax.RREADY, ax.ARVALID, D_wait} !== 3'b001) begin n_fail++; $display("FAIL rm_abort: got rready/arvalid/dwait %b want 001", {ax.RREADY, ax.ARVALID, D_wait}); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rm_buserr_clear: got %b want 0", bus_err); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({ax.RREADY, D_wait} !== 2'b01) begin n_fail++; $display("FAIL rm_quiet%0d: got rready/dwait %b want 01", i, {ax.RREADY, D_wait}); end
    end
    ax.RVALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; D_req = 1'b0; D_write = 1'b0; D_addr = 32'd0; D_in = 32'd0; D_type = 3'b010;
    ax.ARREADY = 1'b0; ax.RID = 4'd1; ax.RDATA = 32'd0; ax.RRESP = 2'b00; ax.RLAST = 1'b0; ax.RVALID = 1'b0;
    ax.AWREADY = 1'b0; ax.WREADY = 1'b0; ax.BID = 4'd1; ax.BRESP = 2'b00; ax.BVALID = 1'b0;
    test_reset();
    test_cached_read();
    test_uncached_read();
    test_writes();
    test_rresp_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
